// File: rtl/csi2_rx_depacketizer.sv
// csi2_rx_depacketizer
// Receive-side CSI-2 depacketizer: parses FS/LS/FE short-packet headers and
// fixed-length RAW8 line payloads from a byte stream, checks header
// sequencing and re-emits the pixels as a RAW8 AXI-Stream with line (tlast)
// and frame (tuser) framing.
//
// Optional feature macro: CSI2_RX_STATS_EN adds saturating stat_frames and
// stat_errors counters as extra output ports.
//
// Handshake semantics (both AXI-Stream ports): a beat transfers on a rising
// clk edge where tvalid && tready are both high; a source holds tvalid and
// its payload stable until that transfer, and tvalid never waits on tready.
//
// dbg_state exposes the parser FSM state: 0 IDLE, 1 HDR, 2 NEXT, 3 PAYLOAD.
module csi2_rx_depacketizer #(
    parameter int         LINE_COUNT      = 16,
    parameter int         PAYLOAD_BYTES   = 512,
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [15:0] frame_number,
    output logic        frame_active,
    output logic        frame_done,
    output logic        err_di,
    output logic        err_sync,
    output logic        err_line_seq,
    output logic        err_line_count,
    output logic        err_frame_id,
`ifdef CSI2_RX_STATS_EN
    output logic [15:0] stat_frames,
    output logic [15:0] stat_errors,
`endif
    output logic [1:0]  dbg_state
);

    localparam int BW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE  = BW'(PAYLOAD_BYTES - 1);
    localparam logic [15:0]   LINES_EXP  = 16'(LINE_COUNT);
    localparam logic [7:0]    DI_FS      = {VIRTUAL_CHANNEL, 6'h00};
    localparam logic [7:0]    DI_FE      = {VIRTUAL_CHANNEL, 6'h01};
    localparam logic [7:0]    DI_LS      = {VIRTUAL_CHANNEL, 6'h02};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_NEXT    = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        HT_FS = 2'd0,
        HT_LS = 2'd1,
        HT_FE = 2'd2
    } hdr_t;

    state_t        state, state_nx;
    hdr_t          hdr_type, start_type;
    logic [1:0]    idx;
    logic [7:0]    hdr_lo, hdr_hi;
    logic [15:0]   hdr_num;
    logic [BW-1:0] byte_cnt;
    logic [15:0]   line_cnt;
    logic          sof_pending;

    // Per-cycle action strobes produced by the next-state logic
    logic accept, is_fs, is_fe, is_ls;
    logic start_hdr, hdr_byte, fs_done, ls_done, fe_done;
    logic pix_take, line_end, drop_frame, e_di, e_sync;

    // The end-of-FE marker carries no information the header does not already give
    logic tlast_unused;
    assign tlast_unused = s_axis_tlast;

    assign accept  = s_axis_tvalid && s_axis_tready;
    assign is_fs   = (s_axis_tdata == DI_FS);
    assign is_fe   = (s_axis_tdata == DI_FE);
    assign is_ls   = (s_axis_tdata == DI_LS);
    assign hdr_num = {hdr_hi, hdr_lo};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // FSM next-state logic and per-byte action decode
    always_comb begin
        state_nx   = state;
        start_hdr  = 1'b0;
        start_type = HT_FS;
        hdr_byte   = 1'b0;
        fs_done    = 1'b0;
        ls_done    = 1'b0;
        fe_done    = 1'b0;
        pix_take   = 1'b0;
        line_end   = 1'b0;
        drop_frame = 1'b0;
        e_di       = 1'b0;
        e_sync     = 1'b0;
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (s_axis_tuser && is_fs) begin
                        start_hdr = 1'b1;
                        state_nx  = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (s_axis_tuser) begin
                        // Sync marker mid-header: abort, resync if it is an FS
                        e_sync = 1'b1;
                        if (is_fs) begin
                            start_hdr = 1'b1;
                            state_nx  = ST_HDR;
                        end else begin
                            drop_frame = 1'b1;
                            state_nx   = ST_IDLE;
                        end
                    end else if (idx == 2'd3) begin
                        // ECC byte completes the header; its value is ignored
                        case (hdr_type)
                            HT_FS: begin
                                fs_done  = 1'b1;
                                state_nx = ST_NEXT;
                            end
                            HT_LS: begin
                                ls_done  = 1'b1;
                                state_nx = ST_PAYLOAD;
                            end
                            default: begin
                                fe_done  = 1'b1;
                                state_nx = ST_IDLE;
                            end
                        endcase
                    end else begin
                        hdr_byte = 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (is_fs && s_axis_tuser) begin
                        start_hdr = 1'b1;
                        state_nx  = ST_HDR;
                    end else if ((is_ls || is_fe) && !s_axis_tuser) begin
                        start_hdr  = 1'b1;
                        start_type = is_ls ? HT_LS : HT_FE;
                        state_nx   = ST_HDR;
                    end else begin
                        e_di       = 1'b1;
                        drop_frame = 1'b1;
                        state_nx   = ST_IDLE;
                    end
                end
                default: begin
                    if (s_axis_tuser) begin
                        // Truncated line: the partial line never gets a tlast
                        e_sync = 1'b1;
                        if (is_fs) begin
                            start_hdr = 1'b1;
                            state_nx  = ST_HDR;
                        end else begin
                            drop_frame = 1'b1;
                            state_nx   = ST_IDLE;
                        end
                    end else begin
                        pix_take = 1'b1;
                        if (byte_cnt == LAST_BYTE) begin
                            line_end = 1'b1;
                            state_nx = ST_NEXT;
                        end
                    end
                end
            endcase
        end
    end

    // FSM outputs: input ready depends on the output register only in PAYLOAD
    always_comb begin
        dbg_state     = state;
        s_axis_tready = 1'b1;
        if (state == ST_PAYLOAD) s_axis_tready = !m_axis_tvalid || m_axis_tready;
    end

    // Header capture, frame/line bookkeeping, error pulses and pixel output register
    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_type       <= HT_FS;
            idx            <= 2'd0;
            hdr_lo         <= 8'd0;
            hdr_hi         <= 8'd0;
            byte_cnt       <= '0;
            line_cnt       <= 16'd0;
            sof_pending    <= 1'b0;
            frame_number   <= 16'd0;
            frame_active   <= 1'b0;
            frame_done     <= 1'b0;
            err_di         <= 1'b0;
            err_sync       <= 1'b0;
            err_line_seq   <= 1'b0;
            err_line_count <= 1'b0;
            err_frame_id   <= 1'b0;
            m_axis_tdata   <= 8'd0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tuser   <= 1'b0;
        end else begin
            frame_done     <= fe_done;
            err_di         <= e_di;
            err_sync       <= e_sync;
            err_line_seq   <= ls_done && (hdr_num != line_cnt);
            err_line_count <= fe_done && (line_cnt != LINES_EXP);
            err_frame_id   <= fe_done && (hdr_num != frame_number);

            if (start_hdr) begin
                hdr_type <= start_type;
                idx      <= 2'd1;
            end else if (hdr_byte) begin
                idx <= idx + 2'd1;
                if (idx == 2'd1) hdr_lo <= s_axis_tdata;
                else             hdr_hi <= s_axis_tdata;
            end

            if (fs_done) begin
                frame_number <= hdr_num;
                line_cnt     <= 16'd0;
                frame_active <= 1'b1;
                sof_pending  <= 1'b1;
            end

            if (fe_done || drop_frame) frame_active <= 1'b0;

            if (ls_done) byte_cnt <= '0;

            if (pix_take) begin
                byte_cnt    <= byte_cnt + 1'b1;
                sof_pending <= 1'b0;
                if (line_end) line_cnt <= line_cnt + 16'd1;
            end

            if (pix_take) begin
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= line_end;
                m_axis_tuser  <= sof_pending;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                m_axis_tuser  <= 1'b0;
            end
        end
    end

`ifdef CSI2_RX_STATS_EN
    logic any_err;
    assign any_err = err_di | err_sync | err_line_seq | err_line_count | err_frame_id;

    // Saturating frame and error-cycle statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_frames <= 16'd0;
            stat_errors <= 16'd0;
        end else begin
            if (frame_done && (stat_frames != 16'hFFFF)) stat_frames <= stat_frames + 16'd1;
            if (any_err && (stat_errors != 16'hFFFF))    stat_errors <= stat_errors + 16'd1;
        end
    end
`endif

endmodule
